// File: rtl/register_file_sb_pkg.sv
// regfile_pkg: shared types and default sizes for the scoreboarded register file.
package regfile_pkg;

   localparam int RF_XLEN  = 32;
   localparam int RF_NREGS = 32;

   // Clear sequencer states.
   typedef enum logic {RF_IDLE, RF_CLEAR} rf_state_t;

   // Register address at the default file size.
   typedef logic [$clog2(RF_NREGS)-1:0] rf_addr_t;

endpackage

// File: rtl/register_file_sb_scoreboard.sv
// regfile_scoreboard: per-register busy bits for RAW hazard tracking.
// A writeback retires the outstanding producer. A reserve marks a new producer.
// clear_all wipes every busy bit. x0 can never become busy.
module regfile_scoreboard #(
   parameter int NREGS = 32,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             idle,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic             rsv_en,
   input  logic [AW-1:0]    rsv_addr,
   input  logic             clear_all,
   output logic             rsv_ready,
   output logic [NREGS-1:0] busy
);

   // Handshake: a reserve is accepted on a rising edge where rsv_en && rsv_ready.
   // rsv_ready never looks at rsv_en. When rsv_ready is low the requester keeps
   // rsv_en and rsv_addr steady and retries. A writeback to the same register
   // in the same cycle frees the slot for the new producer.
   // Accept a reserve when the target is free or is being retired this cycle.
   always_comb begin
      rsv_ready = idle && (!busy[rsv_addr] || (wr_en && (wr_addr == rsv_addr)));
   end

   // Busy bit update. The reserve is applied after the writeback so that the new producer wins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy <= '0;
      end else if (clear_all) begin
         busy <= '0;
      end else begin
         if (idle && wr_en && (wr_addr != '0))
            busy[wr_addr] <= 1'b0;
         if (rsv_en && rsv_ready && (rsv_addr != '0))
            busy[rsv_addr] <= 1'b1;
      end
   end

endmodule

// File: rtl/register_file_sb.sv
// register_file_sb: integer register file with NUM_READ combinational read ports,
// one writeback port, a busy scoreboard and a multi-cycle clear sequencer.
// x0 reads as zero.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle writeback
// data and readiness onto the read ports.
module register_file_sb
   import regfile_pkg::*;
#(
   parameter int XLEN     = RF_XLEN,
   parameter int NREGS    = RF_NREGS,
   parameter int NUM_READ = 2,
   parameter int AW       = $clog2(NREGS)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_READ*AW-1:0]   rs_addr,
   output logic [NUM_READ*XLEN-1:0] rs_data,
   output logic [NUM_READ-1:0]      rs_ready,
   input  logic                     wr_en,
   input  logic [AW-1:0]            wr_addr,
   input  logic [XLEN-1:0]          wr_data,
   input  logic                     rsv_en,
   input  logic [AW-1:0]            rsv_addr,
   output logic                     rsv_ready,
   input  logic                     clear_req,
   output logic                     clear_busy,
   output rf_state_t                dbg_state
);

   localparam logic [AW-1:0] LAST_REG = AW'(NREGS - 1);

   logic [XLEN-1:0]  regs [NREGS];
   logic [NREGS-1:0] busy;
   rf_state_t        state;
   logic [AW-1:0]    clr_cnt;
   logic             idle;
   logic             clear_all;
   logic             wr_fire;

   assign idle       = (state == RF_IDLE);
   assign clear_all  = idle && clear_req;
   assign wr_fire    = idle && wr_en && (wr_addr != '0);
   assign clear_busy = (state == RF_CLEAR);
   assign dbg_state  = state;

   regfile_scoreboard #(
      .NREGS (NREGS),
      .AW    (AW)
   ) u_scoreboard (
      .clk       (clk),
      .reset     (reset),
      .idle      (idle),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .rsv_en    (rsv_en),
      .rsv_addr  (rsv_addr),
      .clear_all (clear_all),
      .rsv_ready (rsv_ready),
      .busy      (busy)
   );

   // Clear sequencer. It walks x1..x(NREGS-1) one register per cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= RF_IDLE;
         clr_cnt <= '0;
      end else begin
         case (state)
            RF_IDLE: begin
               if (clear_req) begin
                  state   <= RF_CLEAR;
                  clr_cnt <= AW'(1);
               end
            end
            RF_CLEAR: begin
               clr_cnt <= clr_cnt + AW'(1);
               if (clr_cnt == LAST_REG)
                  state <= RF_IDLE;
            end
            default: state <= RF_IDLE;
         endcase
      end
   end

   // Data array. Writeback applies only in IDLE. The sequencer zeroes registers while in CLEAR.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int r = 0; r < NREGS; r++)
            regs[r] <= '0;
      end else if (state == RF_CLEAR) begin
         regs[clr_cnt] <= '0;
      end else if (wr_fire) begin
         regs[wr_addr] <= wr_data;
      end
   end

   // Read ports: x0 is forced to zero. Bypass is optional.
   always_comb begin
      rs_data  = '0;
      rs_ready = '0;
      for (int i = 0; i < NUM_READ; i++) begin
         logic [AW-1:0] ra;
         ra = rs_addr[i*AW +: AW];
         rs_data[i*XLEN +: XLEN] = (ra == '0) ? '0 : regs[ra];
         rs_ready[i]             = !busy[ra];
`ifdef REGFILE_BYPASS_EN
         if (wr_fire && (wr_addr == ra)) begin
            rs_data[i*XLEN +: XLEN] = wr_data;
            rs_ready[i]             = 1'b1;
         end
`endif
      end
   end

endmodule

// File: tb/tb_register_file_sb.sv
// Directed bench for register_file_sb: reset, x0, write/read, reserve/writeback,
// the clear sequence and reset during clear. Exercises four read ports.
module tb_register_file_sb;
   import regfile_pkg::*;

   localparam int XLEN = 32;
   localparam int NREGS = 32;
   localparam int NRD = 4;
   localparam int AW = 5;

   logic                 clk;
   logic                 reset;
   logic [NRD*AW-1:0]    rs_addr;
   logic [NRD*XLEN-1:0]  rs_data;
   logic [NRD-1:0]       rs_ready;
   logic                 wr_en;
   logic [AW-1:0]        wr_addr;
   logic [XLEN-1:0]      wr_data;
   logic                 rsv_en;
   logic [AW-1:0]        rsv_addr;
   logic                 rsv_ready;
   logic                 clear_req;
   logic                 clear_busy;
   rf_state_t            dbg_state;

   int n_total = 0;
   int n_bad = 0;

   register_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .NUM_READ(NRD)) dut (
      .clk        (clk),
      .reset      (reset),
      .rs_addr    (rs_addr),
      .rs_data    (rs_data),
      .rs_ready   (rs_ready),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .rsv_en     (rsv_en),
      .rsv_addr   (rsv_addr),
      .rsv_ready  (rsv_ready),
      .clear_req  (clear_req),
      .clear_busy (clear_busy),
      .dbg_state  (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%08h want=0x%08h", tag, obs, exp);
      end
   endtask

   // driver tasks
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_rd(input int port, input logic [AW-1:0] a);
      rs_addr[port*AW +: AW] = a;
   endtask

   function automatic logic [31:0] rd(input int port);
      return rs_data[port*XLEN +: XLEN];
   endfunction

   task automatic write_reg(input logic [AW-1:0] a, input logic [31:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   // Reads all registers four at a time and requires every one to be zero.
   task automatic check_all_zero(input string tag);
      for (int g = 0; g < NREGS / NRD; g++) begin
         for (int p = 0; p < NRD; p++) set_rd(p, AW'(g * NRD + p));
         #1;
         for (int p = 0; p < NRD; p++) check($sformatf("%s_x%0d", tag, g * NRD + p), rd(p), 32'h0);
      end
   endtask

   task automatic fill_all();
      for (int r = 1; r < NREGS; r++) write_reg(AW'(r), 32'h1000 + r);
   endtask

   initial begin
      int cyc;
      reset = 1'b1; rs_addr = '0; wr_en = 0; wr_addr = '0; wr_data = '0;
      rsv_en = 0; rsv_addr = '0; clear_req = 0;
      repeat (2) @(negedge clk);

      // Reset state
      set_rd(0, 1); set_rd(1, 31); set_rd(2, 0); set_rd(3, 5);
      #1;
      check("rst_x1", rd(0), 0);
      check("rst_x31", rd(1), 0);
      check("rst_ready", 32'(rs_ready), 32'hF);
      check("rst_rsv_ready", 32'(rsv_ready), 1);
      check("rst_clear_busy", 32'(clear_busy), 0);
      reset = 1'b0;
      @(negedge clk);

      // x0 writes are dropped
      write_reg(0, 32'hDEADBEEF);
      set_rd(0, 0); #1;
      check("x0_read", rd(0), 0);
      check("x0_ready", 32'(rs_ready[0]), 1);

      // Write x5, read in the same cycle, then in the next cycle
      wr_en = 1; wr_addr = 5; wr_data = 32'h1234; set_rd(0, 5); #1;
`ifdef REGFILE_BYPASS_EN
      check("x5_same_cycle", rd(0), 32'h1234);
`else
      check("x5_same_cycle", rd(0), 32'h0);
`endif
      tick(); wr_en = 0; #1;
      check("x5_next_cycle", rd(0), 32'h1234);

      // Reserve x7, then write back x7
      rsv_en = 1; rsv_addr = 7; set_rd(1, 7); #1;
      check("x7_rsv_ready_pre", 32'(rsv_ready), 1);
      tick(); rsv_en = 0; #1;
      check("x7_busy_ready", 32'(rs_ready[1]), 0);
      check("x7_rsv_ready_busy", 32'(rsv_ready), 0);
      wr_en = 1; wr_addr = 7; wr_data = 32'h55; #1;
      check("x7_rsv_ready_wb", 32'(rsv_ready), 1);
`ifdef REGFILE_BYPASS_EN
      check("x7_ready_same", 32'(rs_ready[1]), 1);
`else
      check("x7_ready_same", 32'(rs_ready[1]), 0);
`endif
      tick(); wr_en = 0; #1;
      check("x7_ready_after_wb", 32'(rs_ready[1]), 1);
      check("x7_data", rd(1), 32'h55);

      // Same-cycle write and reserve of x9
      wr_en = 1; wr_addr = 9; wr_data = 32'hAA; rsv_en = 1; rsv_addr = 9;
      tick(); wr_en = 0; rsv_en = 0; set_rd(2, 9); #1;
      check("x9_data", rd(2), 32'hAA);
      check("x9_busy", 32'(rs_ready[2]), 0);
      // Held reserve of a busy register with no writeback is refused
      rsv_en = 1; #1;
      check("x9_rsv_refused", 32'(rsv_ready), 0);
      rsv_en = 0;

      // Fill, reserve x12, then clear
      fill_all();
      set_rd(0, 1); set_rd(1, 15); set_rd(2, 31); set_rd(3, 12); #1;
      check("fill_x1", rd(0), 32'h1001);
      check("fill_x15", rd(1), 32'h100F);
      check("fill_x31", rd(2), 32'h101F);
      rsv_en = 1; rsv_addr = 12; tick(); rsv_en = 0; #1;
      check("x12_busy", 32'(rs_ready[3]), 0);
      clear_req = 1; tick(); clear_req = 0; #1;
      check("clr_state", 32'(dbg_state), 32'(RF_CLEAR));
      check("clr_x31_old", rd(2), 32'h101F);
      check("clr_busy_wiped", 32'(rs_ready[3]), 1);
      check("clr_rsv_ready", 32'(rsv_ready), 0);
      cyc = 0;
      while (clear_busy && cyc < 40) begin
         if (cyc == 5) begin
            wr_en = 1; wr_addr = 2; wr_data = 32'hBEEF;
         end else begin
            wr_en = 0;
         end
         cyc++;
         tick();
      end
      wr_en = 0;
      check("clr_cycles", 32'(cyc), 31);
      check_all_zero("post_clr");
      write_reg(4, 32'h77);
      set_rd(0, 4); #1;
      check("post_clr_write", rd(0), 32'h77);

      // Reset during clear
      fill_all();
      clear_req = 1; tick(); clear_req = 0;
      repeat (10) tick();
      #1;
      check("mid_clr_busy", 32'(clear_busy), 1);
      reset = 1; #1;
      check("rst_mid_clr_busy", 32'(clear_busy), 0);
      check("rst_mid_clr_state", 32'(dbg_state), 32'(RF_IDLE));
      check_all_zero("rst_mid_clr");
      check("rst_mid_clr_ready", 32'(rs_ready), 32'hF);
      @(negedge clk);
      reset = 0;
      tick();

      // final report
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   // Bound on total run time.
   initial begin
      #200000;
      $display("FAIL timeout: got=running want=finished");
      $fatal(1);
   end

endmodule
